// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write bypass and a per-register
// busy scoreboard that tracks destinations with an outstanding producer.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_busy [NREGS];

  logic [AW-1:0]   w_wr_addr [NWR];
  logic [XLEN-1:0] w_wr_data [NWR];

  // An address is writable/readable only if it exists and is not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr_unpack
      assign w_wr_addr[gi] = wr_addr[gi*AW +: AW];
      assign w_wr_data[gi] = wr_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Later assignments win: higher write ports override lower ones, alloc overrides writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
        r_busy[i] <= 1'b0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && addr_ok(w_wr_addr[w])) begin
          r_regs[w_wr_addr[w]] <= w_wr_data[w];
          r_busy[w_wr_addr[w]] <= 1'b0;
        end
      end
      if (alloc_en && addr_ok(alloc_addr)) begin
        r_busy[alloc_addr] <= 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_data;
      logic            w_busy;

      assign w_ra = rd_addr[gi*AW +: AW];

      always_comb begin
        w_data = '0;
        w_busy = 1'b0;
        if (rst_n && addr_ok(w_ra)) begin
          w_data = r_regs[w_ra];
          w_busy = r_busy[w_ra];
          if (BYPASS != 0) begin
            for (int w = 0; w < NWR; w++) begin
              if (wr_en[w] && (w_wr_addr[w] == w_ra)) begin
                w_data = w_wr_data[w];
                w_busy = 1'b0;
              end
            end
          end
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = w_data;
      assign rd_busy[gi]              = w_busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a 32x32 2R/2W bypassing instance and a
// 24x64 3R/1W non-bypassing instance share clock and reset.
module tb_regfile_sb;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: XLEN=32, NREGS=32, NRD=2, NWR=2, BYPASS=1
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_alloc_en;
  logic [4:0]  a_alloc_addr;

  // Instance B: XLEN=64, NREGS=24, NRD=3, NWR=1, BYPASS=0
  logic [14:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic [0:0]   b_wr_en;
  logic [4:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_alloc_en;
  logic [4:0]   b_alloc_addr;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr)
  );

  regfile_sb #(.XLEN(64), .NREGS(24), .NRD(3), .NWR(1), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr)
  );

  int n_total;
  int n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_wr_en = '0; a_alloc_en = 1'b0;
    b_wr_en = '0; b_alloc_en = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_alloc_en = 1'b0; a_alloc_addr = '0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_alloc_en = 1'b0; b_alloc_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    a_rd_addr = {5'd5, 5'd5};
    #1;
    chk("rst_data", {32'd0, a_rd_data[31:0]}, 64'd0);
    chk("rst_busy", {62'd0, a_rd_busy}, 64'd0);

    // 1: write r5, then asynchronous reset mid-cycle
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'd0, 32'h20};
    tick();
    idle_inputs();
    #1;
    chk("r5_written", {32'd0, a_rd_data[31:0]}, 64'h20);
    rst_n = 1'b0;
    #1;
    chk("r5_async_rst", {32'd0, a_rd_data[31:0]}, 64'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("r5_after_rst", {32'd0, a_rd_data[31:0]}, 64'd0);

    // 2: write 0x20 to r0, r31, r29 on successive edges
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0};  a_wr_data = {32'd0, 32'h20};
    tick();
    a_wr_addr = {5'd0, 5'd31};
    tick();
    a_wr_addr = {5'd0, 5'd29};
    tick();
    idle_inputs();
    a_rd_addr = {5'd29, 5'd31};
    #1;
    chk("rd_r31", {32'd0, a_rd_data[31:0]}, 64'h20);
    chk("rd_r29", {32'd0, a_rd_data[63:32]}, 64'h20);
    a_rd_addr = {5'd0, 5'd0};
    #1;
    chk("rd_r0", {32'd0, a_rd_data[31:0]}, 64'd0);

    // 3: bypass on A (with r7 busy first), no bypass on B
    a_alloc_en = 1'b1; a_alloc_addr = 5'd7;
    tick();
    idle_inputs();
    a_rd_addr = {5'd0, 5'd7};
    #1;
    chk("r7_busy", {62'd0, a_rd_busy}, 64'd1);
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd7}; a_wr_data = {32'd0, 32'hDEADBEEF};
    b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 64'h1234_5678_9ABC_DEF0;
    b_rd_addr = {5'd0, 5'd0, 5'd7};
    #1;
    chk("a_bypass_data", {32'd0, a_rd_data[31:0]}, 64'hDEADBEEF);
    chk("a_bypass_busy", {63'd0, a_rd_busy[0]}, 64'd0);
    chk("b_nobypass_data", b_rd_data[63:0], 64'd0);
    tick();
    idle_inputs();
    #1;
    chk("a_r7_after", {32'd0, a_rd_data[31:0]}, 64'hDEADBEEF);
    chk("a_r7_busy_after", {63'd0, a_rd_busy[0]}, 64'd0);
    chk("b_r7_after", b_rd_data[63:0], 64'h1234_5678_9ABC_DEF0);

    // 4: write conflict, highest port wins (bypass too)
    a_wr_en = 2'b11; a_wr_addr = {5'd3, 5'd3}; a_wr_data = {32'h2222, 32'h1111};
    a_rd_addr = {5'd3, 5'd3};
    #1;
    chk("conflict_bypass", {32'd0, a_rd_data[31:0]}, 64'h2222);
    tick();
    idle_inputs();
    #1;
    chk("conflict_r3", {32'd0, a_rd_data[63:32]}, 64'h2222);

    // 5: scoreboard sequence on r9
    a_rd_addr = {5'd9, 5'd0};
    a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
    tick();
    idle_inputs();
    #1;
    chk("sb_alloc_busy", {63'd0, a_rd_busy[1]}, 64'd1);
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd9}; a_wr_data = {32'd0, 32'h55};
    tick();
    idle_inputs();
    #1;
    chk("sb_wr_busy", {63'd0, a_rd_busy[1]}, 64'd0);
    chk("sb_wr_data", {32'd0, a_rd_data[63:32]}, 64'h55);
    a_wr_en = 2'b10; a_wr_addr = {5'd9, 5'd0}; a_wr_data = {32'h66, 32'd0};
    a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
    tick();
    idle_inputs();
    #1;
    chk("sb_both_busy", {63'd0, a_rd_busy[1]}, 64'd1);
    chk("sb_both_data", {32'd0, a_rd_data[63:32]}, 64'h66);
    a_alloc_en = 1'b1; a_alloc_addr = 5'd0;
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'd0, 32'h77};
    tick();
    idle_inputs();
    a_rd_addr = {5'd9, 5'd0};
    #1;
    chk("sb_r0_busy", {63'd0, a_rd_busy[0]}, 64'd0);
    chk("sb_r0_data", {32'd0, a_rd_data[31:0]}, 64'd0);

    // 6: B out-of-range write/alloc ignored, 64-bit round trip on r23
    b_wr_en = 1'b1; b_wr_addr = 5'd30; b_wr_data = 64'hAAAA_BBBB_CCCC_DDDD;
    b_alloc_en = 1'b1; b_alloc_addr = 5'd30;
    tick();
    idle_inputs();
    b_rd_addr = {5'd0, 5'd0, 5'd30};
    #1;
    chk("b_oor_data", b_rd_data[63:0], 64'd0);
    chk("b_oor_busy", {63'd0, b_rd_busy[0]}, 64'd0);
    b_wr_en = 1'b1; b_wr_addr = 5'd23; b_wr_data = 64'hFEDC_BA98_7654_3210;
    tick();
    idle_inputs();
    b_rd_addr = {5'd23, 5'd23, 5'd23};
    #1;
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("b_r23_p%0d", p), b_rd_data[p*64 +: 64], 64'hFEDC_BA98_7654_3210);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
